// File: rtl/dlfloat16_pkg.sv
// Shared definitions for the DLFloat16 FPU scheduler: widths, opcode and
// FSM state enums, exception-flag bit positions and the opcode-to-unit-select map.
package dlfloat16_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned RES_W  = 20;
    localparam int unsigned FLAG_W = 5;
    localparam int unsigned ENA_W  = 4;
    localparam int unsigned CNT_W  = 3;

    // Bit positions inside {invalid, inexact, overflow, underflow, div_zero}
    localparam int unsigned FLAG_INVALID   = 4;
    localparam int unsigned FLAG_INEXACT   = 3;
    localparam int unsigned FLAG_OVERFLOW  = 2;
    localparam int unsigned FLAG_UNDERFLOW = 1;
    localparam int unsigned FLAG_DIV_ZERO  = 0;

    typedef enum logic [1:0] {
        OP_ADD  = 2'd0,
        OP_MUL  = 2'd1,
        OP_SQRT = 2'd2,
        OP_DIV  = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // One-hot unit select for the shared FPU
    function automatic logic [ENA_W-1:0] op_to_ena(input op_e op);
        return ENA_W'(1) << op;
    endfunction

endpackage

// File: rtl/dlfloat16_rr_arbiter.sv
// Round-robin arbiter: search starts at the requester after the last one
// granted; the pointer moves only when the current grant is consumed.
// Ports: clk, rst_n, req (request vector), advance (grant accepted strobe),
//        grant (one-hot), grant_idx (binary index of grant).
module dlfloat16_rr_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant,
    output logic [IW-1:0]      grant_idx
);

    logic [IW-1:0] ptr;
    logic          found;

    // First asserted request at or after the pointer, wrapping around
    always_comb begin : pick
        int unsigned k;
        k         = 0;
        found     = 1'b0;
        grant_idx = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            k = (32'(ptr) + i) % NUM_REQ;
            if (!found && req[IW'(k)]) begin
                found     = 1'b1;
                grant_idx = IW'(k);
            end
        end
        grant = found ? (NUM_REQ'(1) << grant_idx) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= (grant_idx == IW'(NUM_REQ - 1)) ? '0 : grant_idx + IW'(1);
        end
    end

endmodule

// File: rtl/dlfloat16_fpu_sched.sv
// Shares one registered DLFloat16 FPU between NUM_REQ requesters.
// One operation at a time: IDLE (arbitrate/accept) -> EXEC (drive FPU for
// LAT+1 cycles) -> RESP (hold result for the owner until it is taken).
// Ports: clk, rst_n; req_valid/req_ready/req_op/req_a/req_b (request side);
//        resp_valid/resp_ready/resp_data/resp_flags (response side);
//        fpu_ena/fpu_a/fpu_b (to FPU), fpu_result/fpu_flags (from FPU).
module dlfloat16_fpu_sched
    import dlfloat16_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned LAT     = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [2*NUM_REQ-1:0]    req_op,
    input  logic [16*NUM_REQ-1:0]   req_a,
    input  logic [16*NUM_REQ-1:0]   req_b,
    output logic [NUM_REQ-1:0]      resp_valid,
    input  logic [NUM_REQ-1:0]      resp_ready,
    output logic [RES_W-1:0]        resp_data,
    output logic [FLAG_W-1:0]       resp_flags,
    output logic [ENA_W-1:0]        fpu_ena,
    output logic [DATA_W-1:0]       fpu_a,
    output logic [DATA_W-1:0]       fpu_b,
    input  logic [RES_W-1:0]        fpu_result,
    input  logic [FLAG_W-1:0]       fpu_flags
);

    localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_e             state;
    logic [CNT_W-1:0]   cnt;
    logic               armed;
    logic [IW-1:0]      owner;
    logic [NUM_REQ-1:0] grant;
    logic [IW-1:0]      grant_idx;
    logic               accept;
    logic [1:0]         sel_op;
    logic [DATA_W-1:0]  sel_a;
    logic [DATA_W-1:0]  sel_b;

    dlfloat16_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req_valid),
        .advance   (accept),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // armed blocks an accept on the first edge after reset release
    assign req_ready = (state == ST_IDLE && armed) ? grant : '0;
    assign accept    = |(req_valid & req_ready);

    // Operand mux driven by the one-hot grant
    always_comb begin
        sel_op = '0;
        sel_a  = '0;
        sel_b  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_op = req_op[2*i +: 2];
                sel_a  = req_a[16*i +: 16];
                sel_b  = req_b[16*i +: 16];
            end
        end
    end

    // Scheduler FSM; FPU drive registers double as the latched operation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            armed      <= 1'b0;
            owner      <= '0;
            resp_valid <= '0;
            resp_data  <= '0;
            resp_flags <= '0;
            fpu_ena    <= '0;
            fpu_a      <= '0;
            fpu_b      <= '0;
        end else begin
            armed <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state   <= ST_EXEC;
                        cnt     <= '0;
                        owner   <= grant_idx;
                        fpu_ena <= op_to_ena(op_e'(sel_op));
                        fpu_a   <= sel_a;
                        fpu_b   <= sel_b;
                    end
                end
                ST_EXEC: begin
                    // cnt runs 0..LAT, giving LAT+1 EXEC cycles
                    if (cnt == CNT_W'(LAT)) begin
                        state      <= ST_RESP;
                        cnt        <= '0;
                        fpu_ena    <= '0;
                        fpu_a      <= '0;
                        fpu_b      <= '0;
                        resp_data  <= fpu_result;
                        resp_flags <= fpu_flags;
                        resp_valid <= NUM_REQ'(1) << owner;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    // resp_valid is one-hot on the owner, so non-owner ready is masked
                    if (|(resp_valid & resp_ready)) begin
                        state      <= ST_IDLE;
                        resp_valid <= '0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dlfloat16_fpu_sched.sv
// Self-checking bench for dlfloat16_fpu_sched: LAT=1 instance exercised with
// directed and random traffic, LAT=3 instance for the longer pipeline.
module tb_dlfloat16_fpu_sched;
    import dlfloat16_pkg::*;

    localparam int NR   = 2;
    localparam int LAT1 = 1;
    localparam int LAT3 = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // LAT=1 instance
    logic [NR-1:0]    req_valid, req_ready, resp_valid, resp_ready;
    logic [2*NR-1:0]  req_op;
    logic [16*NR-1:0] req_a, req_b;
    logic [19:0]      resp_data, fpu_result;
    logic [4:0]       resp_flags, fpu_flags;
    logic [3:0]       fpu_ena;
    logic [15:0]      fpu_a, fpu_b;

    // LAT=3 instance
    logic [NR-1:0]    req_valid3, req_ready3, resp_valid3, resp_ready3;
    logic [2*NR-1:0]  req_op3;
    logic [16*NR-1:0] req_a3, req_b3;
    logic [19:0]      resp_data3, fpu_result3;
    logic [4:0]       resp_flags3, fpu_flags3;
    logic [3:0]       fpu_ena3;
    logic [15:0]      fpu_a3, fpu_b3;

    logic [1:0]  op_q [NR];
    logic [15:0] a_q  [NR];
    logic [15:0] b_q  [NR];

    for (genvar i = 0; i < NR; i++) begin : g_pack
        assign req_op[2*i +: 2] = op_q[i];
        assign req_a[16*i +: 16] = a_q[i];
        assign req_b[16*i +: 16] = b_q[i];
    end

    dlfloat16_fpu_sched #(.NUM_REQ(NR), .LAT(LAT1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_flags(resp_flags),
        .fpu_ena(fpu_ena), .fpu_a(fpu_a), .fpu_b(fpu_b),
        .fpu_result(fpu_result), .fpu_flags(fpu_flags)
    );

    dlfloat16_fpu_sched #(.NUM_REQ(NR), .LAT(LAT3)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid3), .req_ready(req_ready3), .req_op(req_op3),
        .req_a(req_a3), .req_b(req_b3),
        .resp_valid(resp_valid3), .resp_ready(resp_ready3),
        .resp_data(resp_data3), .resp_flags(resp_flags3),
        .fpu_ena(fpu_ena3), .fpu_a(fpu_a3), .fpu_b(fpu_b3),
        .fpu_result(fpu_result3), .fpu_flags(fpu_flags3)
    );

    // FPU stub contract: {flags, result} as a pure function of the unit select and operands
    function automatic logic [24:0] fpu_fn(input logic [3:0] ena, input logic [15:0] a,
                                           input logic [15:0] b);
        logic [19:0] r;
        logic [4:0]  f;
        if (ena == 4'b0000) return 25'h0;
        if (ena == 4'b0100 && a[15]) return {5'b10000, 20'hFFFFF};
        r = {a, 4'h0} ^ {4'h0, b};
        if (ena != 4'b0100) r = r ^ {ena, 16'h0};
        f = a[4:0] ^ b[4:0];
        return {f, r};
    endfunction

    // Registered FPU stubs with LAT stages
    logic [24:0] p1;
    logic [24:0] p3 [LAT3];
    always @(posedge clk) begin
        p1    <= fpu_fn(fpu_ena, fpu_a, fpu_b);
        p3[0] <= fpu_fn(fpu_ena3, fpu_a3, fpu_b3);
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign fpu_result  = p1[19:0];
    assign fpu_flags   = p1[24:20];
    assign fpu_result3 = p3[2][19:0];
    assign fpu_flags3  = p3[2][24:20];

    int checks   = 0;
    int failures = 0;
    int rr_last  = -1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Round-robin reference: first valid index strictly after the last grant
    function automatic int next_grant(input logic [NR-1:0] v);
        int idx;
        for (int off = 1; off <= NR; off++) begin
            idx = (rr_last + off) % NR;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [NR-1:0] onehot(input int g);
        logic [NR-1:0] r;
        r = '0;
        if (g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    task automatic new_op(input int i);
        op_q[i] = 2'($urandom_range(0, 3));
        a_q[i]  = 16'($urandom);
        b_q[i]  = 16'($urandom);
    endtask

    // One full transaction on the LAT=1 instance, checked cycle by cycle
    task automatic txn(input int bp, input bit keep, input bit noise, input bit other_ready);
        int          g, t;
        logic [3:0]  eena;
        logic [15:0] ea, eb;
        logic [24:0] exp_r;
        #1;
        t = 0;
        while (!(|req_ready) && t < 30) begin
            @(negedge clk); #1; t++;
        end
        g = next_grant(req_valid);
        check("grant", 32'(req_ready), 32'(onehot(g)));
        if (g < 0) return;
        eena  = 4'b0001 << op_q[g];
        ea    = a_q[g];
        eb    = b_q[g];
        exp_r = fpu_fn(eena, ea, eb);
        resp_ready = (bp == 0) ? '1 : (other_ready ? ~onehot(g) : '0);
        rr_last = g;
        for (int k = 0; k <= LAT1; k++) begin
            @(negedge clk);
            if (k == 0) begin
                if (keep) new_op(g);
                else req_valid[g] = 1'b0;
            end
            if (noise) req_valid[1-g] = 1'($urandom_range(0, 1));
            #1;
            check("exec_ena", 32'(fpu_ena), 32'(eena));
            check("exec_a", 32'(fpu_a), 32'(ea));
            check("exec_b", 32'(fpu_b), 32'(eb));
            check("exec_req_ready", 32'(req_ready), 32'h0);
            check("exec_resp_valid", 32'(resp_valid), 32'h0);
        end
        @(negedge clk); #1;
        check("resp_valid", 32'(resp_valid), 32'(onehot(g)));
        check("resp_data", 32'(resp_data), 32'(exp_r[19:0]));
        check("resp_flags", 32'(resp_flags), 32'(exp_r[24:20]));
        for (int k = 0; k < bp; k++) begin
            @(negedge clk);
            if (noise) req_valid[1-g] = 1'($urandom_range(0, 1));
            #1;
            check("bp_resp_valid", 32'(resp_valid), 32'(onehot(g)));
            check("bp_resp_data", 32'(resp_data), 32'(exp_r[19:0]));
            check("bp_resp_flags", 32'(resp_flags), 32'(exp_r[24:20]));
            check("bp_req_ready", 32'(req_ready), 32'h0);
            check("bp_fpu_ena", 32'(fpu_ena), 32'h0);
        end
        resp_ready[g] = 1'b1;
        @(negedge clk);
        resp_ready = '0;
        #1;
        check("hs_resp_valid", 32'(resp_valid), 32'h0);
        check("idle_grant", 32'(req_ready), 32'(onehot(next_grant(req_valid))));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [24:0] e3;
        logic [15:0] a3, b3;
        int          t;

        rst_n = 1'b0;
        req_valid = '1;
        resp_ready = '0;
        for (int i = 0; i < NR; i++) begin
            op_q[i] = 2'd0; a_q[i] = 16'h0; b_q[i] = 16'h0;
        end
        req_valid3 = '0; resp_ready3 = '0; req_op3 = '0; req_a3 = '0; req_b3 = '0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_req_ready", 32'(req_ready), 32'h0);
        check("rst_resp_valid", 32'(resp_valid), 32'h0);
        check("rst_resp_data", 32'(resp_data), 32'h0);
        check("rst_resp_flags", 32'(resp_flags), 32'h0);
        check("rst_fpu_ena", 32'(fpu_ena), 32'h0);
        check("rst_fpu_a", 32'(fpu_a), 32'h0);
        check("rst_fpu_b", 32'(fpu_b), 32'h0);

        // No accept on the first edge after release
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("first_edge_ready", 32'(req_ready), 32'h0);
        @(negedge clk); #1;
        check("armed_ready", 32'(req_ready), 32'h1);

        // Valid dropped in the grant cycle: no accept, pointer unchanged
        req_valid = 2'b01;
        #1;
        check("drop_grant", 32'(req_ready), 32'h1);
        #1;
        req_valid = 2'b00;
        #1;
        check("drop_ready", 32'(req_ready), 32'h0);
        @(negedge clk); #1;
        check("drop_no_exec", 32'(fpu_ena), 32'h0);
        req_valid = 2'b11;
        #1;
        check("drop_ptr_kept", 32'(req_ready), 32'h1);

        // Single sqrt
        req_valid = 2'b01;
        op_q[0] = 2'd2; a_q[0] = 16'h3E00; b_q[0] = 16'h0000;
        txn(0, 1'b0, 1'b0, 1'b0);
        check("sqrt_data", 32'(resp_data), 32'h3E000);
        check("sqrt_flags", 32'(resp_flags), 32'h0);

        // Negative sqrt raises invalid
        op_q[0] = 2'd2; a_q[0] = 16'hBE00; b_q[0] = 16'h0000;
        req_valid = 2'b01;
        txn(0, 1'b0, 1'b0, 1'b0);
        check("nsqrt_data", 32'(resp_data), 32'hFFFFF);
        check("nsqrt_flags", 32'(resp_flags), 32'h10);

        // Contention: both valid throughout, non-owner ready held high
        new_op(0); new_op(1);
        req_valid = 2'b11;
        for (int n = 0; n < 4; n++) txn($urandom_range(0, 2), 1'b1, 1'b0, 1'b1);

        // Back-pressure for 5 cycles
        txn(5, 1'b1, 1'b0, 1'b1);

        // Random traffic with valid noise during EXEC/RESP
        for (int n = 0; n < 10; n++) begin
            if (req_valid == '0) begin
                new_op(0); new_op(1);
                req_valid = 2'($urandom_range(1, 3));
            end
            txn($urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1)));
        end

        // Reset mid-EXEC after a grant to requester 0
        req_valid = '0;
        @(negedge clk);
        if (rr_last == 0) begin
            // move pointer-equivalent state so that requester 0 is granted next
            new_op(1); req_valid = 2'b10;
            txn(0, 1'b0, 1'b0, 1'b0);
        end
        new_op(0);
        req_valid = 2'b01;
        #1;
        t = 0;
        while (!(|req_ready) && t < 30) begin
            @(negedge clk); #1; t++;
        end
        check("abort_grant", 32'(req_ready), 32'h1);
        @(negedge clk); #1;
        check("abort_exec_ena", 32'(fpu_ena), 32'(4'b0001 << op_q[0]));
        rst_n = 1'b0;
        req_valid = 2'b11;
        #1;
        check("abort_ena", 32'(fpu_ena), 32'h0);
        check("abort_a", 32'(fpu_a), 32'h0);
        check("abort_b", 32'(fpu_b), 32'h0);
        check("abort_req_ready", 32'(req_ready), 32'h0);
        check("abort_resp_valid", 32'(resp_valid), 32'h0);
        check("abort_resp_data", 32'(resp_data), 32'h0);
        check("abort_resp_flags", 32'(resp_flags), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rr_last = -1;
        #1;
        check("post_rst_first", 32'(req_ready), 32'h0);
        check("post_rst_resp", 32'(resp_valid), 32'h0);
        @(negedge clk); #1;
        check("post_rst_grant0", 32'(req_ready), 32'h1);
        check("post_rst_resp2", 32'(resp_valid), 32'h0);
        new_op(0); new_op(1);
        txn(1, 1'b0, 1'b0, 1'b1);
        txn(0, 1'b0, 1'b0, 1'b0);

        // LAT=3 instance: div from requester 1
        a3 = 16'($urandom); b3 = 16'($urandom);
        req_op3 = {2'd3, 2'd0};
        req_a3 = {a3, 16'h0};
        req_b3 = {b3, 16'h0};
        e3 = fpu_fn(4'b1000, a3, b3);
        resp_ready3 = '1;
        req_valid3 = 2'b10;
        #1;
        t = 0;
        while (!(|req_ready3) && t < 30) begin
            @(negedge clk); #1; t++;
        end
        check("l3_grant", 32'(req_ready3), 32'h2);
        for (int k = 0; k <= LAT3; k++) begin
            @(negedge clk);
            if (k == 0) req_valid3 = '0;
            #1;
            check("l3_exec_ena", 32'(fpu_ena3), 32'h8);
            check("l3_exec_a", 32'(fpu_a3), 32'(a3));
            check("l3_exec_resp_valid", 32'(resp_valid3), 32'h0);
        end
        @(negedge clk); #1;
        check("l3_resp_valid", 32'(resp_valid3), 32'h2);
        check("l3_resp_data", 32'(resp_data3), 32'(e3[19:0]));
        check("l3_resp_flags", 32'(resp_flags3), 32'(e3[24:20]));
        check("l3_ena_off", 32'(fpu_ena3), 32'h0);
        @(negedge clk); #1;
        check("l3_hs", 32'(resp_valid3), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dlfloat16_fpu_sched.md
DLFLOAT16_FPU_SCHED -- requirements
Module: dlfloat16_fpu_sched

Interface
REQ-001 Parameter NUM_REQ, default 2: number of requester ports.
REQ-002 Parameter LAT, default 1: FPU register latency in cycles, from the cycle `fpu_ena` is applied to the cycle the result is visible. Legal range 1..7.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 req_valid  input  NUM_REQ  per-requester operation request.
REQ-006 req_ready  output  NUM_REQ  per-requester accept; a request is accepted when valid and ready are both high at a clock edge.
REQ-007 req_op  input  2*NUM_REQ  per-requester opcode: 0=add, 1=mul, 2=sqrt, 3=div.
REQ-008 req_a, req_b  input  16*NUM_REQ  per-requester DLFloat16 operands.
REQ-009 resp_valid  output  NUM_REQ  result available for the owning requester.
REQ-010 resp_ready  input  NUM_REQ  requester accepts the result.
REQ-011 resp_data  output  20  captured FPU result, shared by all requesters.
REQ-012 resp_flags  output  5  captured exception flags {invalid, inexact, overflow, underflow, div_zero}.
REQ-013 fpu_ena  output  4  one-hot unit select to the shared FPU; equals 1<<op, e.g. sqrt=4'b0100.
REQ-014 fpu_a, fpu_b  output  16  operands to the shared FPU.
REQ-015 fpu_result  input  20  registered FPU result.
REQ-016 fpu_flags  input  5  registered FPU exception flags.

Function
REQ-017 The FSM SHALL have three states:
  - IDLE -> EXEC on accept.
  - EXEC -> RESP after exactly LAT+1 cycles, counted by a 3-bit counter.
  - RESP -> IDLE on the edge where `resp_valid` and `resp_ready` of the owner are both high.
REQ-018 `req_ready` SHALL be high only in IDLE, and only for the single requester selected by the round-robin arbiter among the asserted `req_valid` bits.
REQ-019 Round-robin arbitration:
  - Priority starts at the index after the last granted requester.
  - After reset, requester 0 has highest priority.
  - The pointer advances only on an accepted request.
REQ-020 On accept, the block SHALL latch op, a, b and the owner index.
REQ-021 Throughout EXEC, `fpu_ena`, `fpu_a` and `fpu_b` SHALL be driven from the latched values and held stable.
REQ-022 Outside EXEC, `fpu_ena` SHALL be 4'b0000 and `fpu_a`/`fpu_b` SHALL be 0.
REQ-023 On the last EXEC edge, `fpu_result` and `fpu_flags` SHALL be captured into `resp_data` and `resp_flags`.
REQ-024 Latency: if accept occurs at the edge ending cycle N, `resp_valid` of the owner SHALL go high in cycle N+LAT+2.
REQ-025 In RESP, `resp_valid` SHALL be high only for the owner, with `resp_data`/`resp_flags` stable until the handshake; `resp_ready` of non-owners SHALL be ignored.
REQ-026 Each requester SHALL have at most one operation outstanding; throughput is one operation per LAT+3 cycles minimum.
REQ-027 Boundary conditions:
  - `req_valid` changes during EXEC/RESP SHALL have no effect.
  - `req_valid` dropping in the same cycle as the grant means no accept.
  - If `resp_ready` is already high on RESP entry, the block SHALL return to IDLE after one RESP cycle.
  - An accept may occur in the first IDLE cycle after RESP.

Reset
REQ-028 While `rst_n` is low, the block SHALL hold:
  - state=IDLE, counter=0, arbiter pointer=0;
  - `req_ready`=0, `resp_valid`=0;
  - `resp_data`=20'h0, `resp_flags`=5'h0;
  - `fpu_ena`=4'h0, `fpu_a`/`fpu_b`=0.
REQ-029 Reset asserted mid-EXEC or mid-RESP SHALL abort the operation with no response issued; the first accept after reset deassertion is permitted at the second rising edge.

Structure
REQ-030 A shared package `dlfloat16_pkg` SHALL hold:
  - the opcode enum (ADD/MUL/SQRT/DIV);
  - the FSM state enum;
  - the flag-bit index constants;
  - the op-to-one-hot `fpu_ena` mapping function.
REQ-031 Round-robin selection SHALL be a sub-module `dlfloat16_rr_arbiter` (request vector, grant one-hot, advance strobe).

Verification
REQ-032 Single sqrt, LAT=1:
  - Stimulus: req0 op=2, a=16'h3E00, accepted at edge N; FPU stub returns result=20'h3E000, flags=0.
  - Response: `fpu_ena`=4'b0100 for 2 cycles; `resp_valid[0]` in cycle N+3; `resp_data`=20'h3E000.
REQ-033 Negative sqrt:
  - Stimulus: a=16'hBE00; stub returns 20'hFFFFF, flags=5'b10000.
  - Response: `resp_flags`=5'b10000, `resp_data`=20'hFFFFF.
REQ-034 Contention: both requesters valid continuously -> grants alternate 0,1,0,1; each response returns only to its owner.
REQ-035 Back-pressure: `resp_ready` held low 5 cycles -> `resp_valid`/`resp_data` stable, `req_ready`=0 throughout, and `fpu_ena`=0.
REQ-036 Reset during EXEC -> all outputs zero within the reset, no `resp_valid`, and the next grant goes to requester 0.
REQ-037 LAT=3: accept at edge N -> EXEC for 4 cycles, `resp_valid` in cycle N+5.
